// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Data wins by default; a fetch is forced through after FAIR_LIMIT data grants.
module mem_port_arbiter #(
  parameter int BIT_WIDTH  = 32,
  parameter int FAIR_LIMIT = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 bus_err,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t               state_q, state_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [7:0]           wcnt_q, wcnt_d;
  logic                 m_req_q, m_req_d;
  logic                 m_write_q, m_write_d;
  logic [1:0]           m_size_q, m_size_d;
  logic [BIT_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [BIT_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [BIT_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [BIT_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 bus_err_q, bus_err_d;

  logic i_pend, d_pend, force_i, acked, tmo;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    m_req_d   = m_req_q;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    // a requester still shows its request during its own ack cycle
    i_pend  = i_req & ~i_ack_q;
    d_pend  = d_req & ~d_ack_q;
    force_i = i_pend & d_pend & (fcnt_q == 4'(FAIR_LIMIT));
    acked   = ~m_ack_n;
    tmo     = (wcnt_q == 8'(MAX_WAIT - 1));
    unique case (state_q)
      IDLE: begin
        if (d_pend && !force_i) begin
          state_d   = DBUSY;
          m_req_d   = 1'b1;
          m_write_d = d_write;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          wcnt_d    = '0;
          if (i_pend && fcnt_q != 4'hF)
            fcnt_d = fcnt_q + 4'd1;
        end else if (i_pend) begin
          state_d   = IBUSY;
          m_req_d   = 1'b1;
          m_write_d = 1'b0;
          m_size_d  = 2'b00;
          m_addr_d  = i_addr;
          wcnt_d    = '0;
          fcnt_d    = '0;
        end
      end
      IBUSY, DBUSY: begin
        wcnt_d = wcnt_q + 8'd1;
        if (acked || tmo) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          bus_err_d = ~acked;
          if (state_q == IBUSY) begin
            i_ack_d   = 1'b1;
            i_rdata_d = acked ? m_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!acked)
              d_rdata_d = '0;
            else if (!m_write_q)
              d_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      m_req_q   <= m_req_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int W    = 32;
  localparam int FAIR = 4;
  localparam int MAXW = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_write, m_ack_n;
  logic [1:0]   d_size;
  logic [W-1:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic         i_ack, d_ack, bus_err, m_req, m_write;
  logic [1:0]   m_size;

  mem_port_arbiter #(.BIT_WIDTH(W), .FAIR_LIMIT(FAIR), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_err(bus_err), .m_req(m_req), .m_write(m_write), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: owner 0 none, 1 fetch, 2 data
  int           owner, busy, streak;
  logic         e_mreq, e_mwrite, e_iack, e_dack, e_err;
  logic [1:0]   e_msize;
  logic [W-1:0] e_maddr, e_mwdata, e_irdata, e_drdata;

  task automatic model_reset();
    owner = 0; busy = 0; streak = 0;
    e_mreq = 0; e_mwrite = 0; e_iack = 0; e_dack = 0; e_err = 0;
    e_msize = 0; e_maddr = 0; e_mwdata = 0; e_irdata = 0; e_drdata = 0;
  endtask

  task automatic model_step();
    bit ip, dp, got;
    ip = i_req && !e_iack;
    dp = d_req && !e_dack;
    e_iack = 0; e_dack = 0; e_err = 0;
    if (owner == 0) begin
      if (dp && !(ip && streak >= FAIR)) begin
        owner = 2; busy = 1; e_mreq = 1;
        e_mwrite = d_write; e_msize = d_size;
        e_maddr = d_addr; e_mwdata = d_wdata;
        if (ip && streak < 15) streak++;
      end else if (ip) begin
        owner = 1; busy = 1; e_mreq = 1;
        e_mwrite = 0; e_msize = 0; e_maddr = i_addr;
        streak = 0;
      end
    end else begin
      got = !m_ack_n;
      if (got || busy >= MAXW) begin
        if (owner == 1) begin
          e_iack = 1;
          e_irdata = got ? m_rdata : '0;
        end else begin
          e_dack = 1;
          if (!got) e_drdata = '0;
          else if (!e_mwrite) e_drdata = m_rdata;
        end
        e_err = !got; e_mreq = 0; owner = 0;
      end else begin
        busy++;
      end
    end
  endtask

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("i_ack", W'(i_ack), W'(e_iack));
    chk("d_ack", W'(d_ack), W'(e_dack));
    chk("bus_err", W'(bus_err), W'(e_err));
    chk("m_req", W'(m_req), W'(e_mreq));
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    if (e_mreq) begin
      chk("m_addr", m_addr, e_maddr);
      chk("m_wdata_wr", W'(m_write), W'(e_mwrite));
      chk("m_size", W'(m_size), W'(e_msize));
      if (e_mwrite) chk("m_wdata", m_wdata, e_mwdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  bit i_served, d_served;
  int ackp;

  initial begin
    rst = 1; i_req = 0; d_req = 0; d_write = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack_n = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_m_addr", m_addr, '0);
    chk("rst_m_wdata", m_wdata, '0);
    chk("rst_m_write", W'(m_write), '0);
    chk("rst_m_size", W'(m_size), '0);
    rst = 0;
    tick();

    // single fetch
    i_req = 1; i_addr = 32'h0000_0040;
    tick();
    chk("t1_mreq", W'(m_req), 1);
    chk("t1_addr", m_addr, 32'h40);
    chk("t1_size", W'(m_size), 0);
    m_ack_n = 0; m_rdata = 32'h2008_0005;
    tick();
    chk("t1_iack", W'(i_ack), 1);
    chk("t1_rdata", i_rdata, 32'h2008_0005);
    m_ack_n = 1;
    tick();
    chk("t1_mask", W'(m_req), 0);
    i_req = 0;
    tick();

    // simultaneous requests: data first, fetch on the d_ack cycle
    i_req = 1; i_addr = 32'h0000_0100;
    d_req = 1; d_write = 0; d_size = 2'b01; d_addr = 32'h0800_0010;
    tick();
    chk("t2_addr", m_addr, 32'h0800_0010);
    chk("t2_size", W'(m_size), 1);
    m_ack_n = 0; m_rdata = 32'hCAFE_BABE;
    tick();
    chk("t2_dack", W'(d_ack), 1);
    chk("t2_drdata", d_rdata, 32'hCAFE_BABE);
    m_ack_n = 1;
    tick();
    chk("t2_fetch", m_addr, 32'h100);
    d_req = 0; m_ack_n = 0; m_rdata = 32'h1111_2222;
    tick();
    m_ack_n = 1;
    tick();
    i_req = 0;
    tick();

    // fairness: fetch withdrawn during each d_ack cycle
    i_addr = 32'h0000_0200; d_addr = 32'h0000_3000; d_size = 0;
    for (int k = 0; k < FAIR; k++) begin
      i_req = 1; d_req = 1;
      tick();
      chk("t3_data", m_addr, 32'h3000);
      m_ack_n = 0; m_rdata = 32'h3000 + k;
      tick();
      i_req = 0; m_ack_n = 1;
      tick();
    end
    i_req = 1; d_req = 1;
    tick();
    chk("t3_forced", m_addr, 32'h200);
    m_ack_n = 0;
    tick();
    i_req = 0; d_req = 0; m_ack_n = 1;
    tick();
    i_req = 1; d_req = 1;
    tick();
    chk("t3_cleared", m_addr, 32'h3000);
    m_ack_n = 0; m_rdata = 32'h5555_AAAA;
    tick();
    d_req = 0; m_ack_n = 1;
    tick();
    m_ack_n = 0;
    tick();
    i_req = 0; m_ack_n = 1;
    tick();

    // store: operands stable, d_rdata untouched
    d_req = 1; d_write = 1; d_addr = 32'hF000_0000;
    d_wdata = 32'h41; d_size = 2'b10;
    tick();
    chk("t4_write", W'(m_write), 1);
    d_wdata = 32'hBAD0_BAD0; d_addr = 32'h1234_5678;
    repeat (3) tick();
    chk("t4_wdata", m_wdata, 32'h41);
    chk("t4_addr", m_addr, 32'hF000_0000);
    m_ack_n = 0; m_rdata = 32'hDEAD_DEAD;
    tick();
    chk("t4_keep", d_rdata, 32'h5555_AAAA);
    m_ack_n = 1;
    tick();
    d_req = 0; d_write = 0;
    tick();

    // timeout, then ack on the last allowed cycle
    d_req = 1; d_addr = 32'h0000_0400;
    tick();
    for (int c = 1; c <= MAXW; c++) begin
      chk("t5_mreq_hold", W'(m_req), 1);
      tick();
    end
    chk("t5_dack", W'(d_ack), 1);
    chk("t5_err", W'(bus_err), 1);
    chk("t5_zero", d_rdata, 0);
    tick();
    d_req = 0;
    tick();
    d_req = 1;
    tick();
    repeat (MAXW - 1) tick();
    m_ack_n = 0; m_rdata = 32'h7777_0001;
    tick();
    chk("t5_late_ack", W'(d_ack), 1);
    chk("t5_no_err", W'(bus_err), 0);
    chk("t5_late_data", d_rdata, 32'h7777_0001);
    m_ack_n = 1;
    tick();
    d_req = 0;
    tick();

    // reset in the middle of a data transaction
    i_req = 1; i_addr = 32'h0000_0500; d_req = 1;
    tick();
    tick();
    rst = 1;
    #1;
    chk("t6_rst_mreq", W'(m_req), 0);
    chk("t6_rst_dack", W'(d_ack), 0);
    model_reset();
    tick();
    rst = 0; d_req = 0;
    tick();
    chk("t6_fetch", m_addr, 32'h500);
    m_ack_n = 0;
    tick();
    m_ack_n = 1;
    tick();
    i_req = 0;
    tick();

    // random traffic
    i_served = 0; d_served = 0;
    for (int n = 0; n < 3000; n++) begin
      ackp = (n % 1000 < 700) ? 3 : 40;
      if (e_iack) i_served = 1;
      else if (i_served || !i_req) begin
        i_served = 0;
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = $urandom;
      end
      if (e_dack) d_served = 1;
      else if (d_served || !d_req) begin
        d_served = 0;
        d_req = ($urandom_range(0, 2) != 0);
        d_write = $urandom_range(0, 1);
        d_size = 2'($urandom_range(0, 3));
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      m_ack_n = ($urandom_range(0, ackp) != 0);
      m_rdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
